// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter sequencer.
//   PC_SEL_W : width of the next-PC source select
//   pc_sel_t : next-PC source encoding; codes 5..7 are treated as increment
package pc_pkg;

   localparam int PC_SEL_W = 3;

   typedef enum logic [PC_SEL_W-1:0] {
      PC_INC  = 3'd0,
      PC_BR   = 3'd1,
      PC_JMP  = 3'd2,
      PC_CALL = 3'd3,
      PC_RET  = 3'd4
   } pc_sel_t;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   i_clk     clock, rising edge
//   i_reset   asynchronous active-low reset
//   i_push    push i_data (push while full overwrites the oldest entry)
//   i_pop     pop top entry (pop while empty leaves the stack empty)
//   i_data    return address to push
//   o_top     current top-of-stack entry (valid only when not empty)
//   o_empty   stack holds no entries
//   o_full    stack holds RAS_DEPTH entries
//   o_ovf     one-cycle pulse after a push while full
//   o_unf     one-cycle pulse after a pop while empty
// Entry contents are not reset.
module pc_ras #(
   parameter int ADDR_W    = 7,
   parameter int RAS_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [ADDR_W-1:0] i_data,
   output logic [ADDR_W-1:0] o_top,
   output logic              o_empty,
   output logic              o_full,
   output logic              o_ovf,
   output logic              o_unf
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

   logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
   logic [PTR_W-1:0]  r_ptr;   // next slot to write; top sits one below
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf;
   logic              r_unf;
   logic              w_empty;
   logic              w_full;

   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == CNT_FULL);

   // Pointer wraps naturally because the depth is a power of two, so a
   // push while full simply lands on the oldest entry.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_ptr <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_ovf <= i_push && w_full;
         r_unf <= i_pop && w_empty;
         if (i_push) begin
            r_ptr <= r_ptr + PTR_ONE;
            if (!w_full) begin
               r_cnt <= r_cnt + CNT_ONE;
            end
         end else if (i_pop && !w_empty) begin
            r_ptr <= r_ptr - PTR_ONE;
            r_cnt <= r_cnt - CNT_ONE;
         end
      end
   end

   assign o_top   = r_mem[r_ptr - PTR_ONE];
   assign o_empty = w_empty;
   assign o_full  = w_full;
   assign o_ovf   = r_ovf;
   assign o_unf   = r_unf;

endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer for the single-cycle core.
// Holds the PC and selects the next address from increment, relative branch,
// absolute jump, call, return or trap vector, with stall support.
// Optional feature macro: PC_RAS_EN (adds the return-address stack).
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_stall      hold PC and RAS this cycle
//   i_trap       redirect to TRAP_VEC (overrides stall and select)
//   i_pc_sel     next-PC source (pc_sel_t)
//   i_br_off     signed branch offset
//   i_jmp_tgt    jump/call target; also fallback for RET on empty stack
//   o_pc         current PC (registered)
//   o_pc_plus1   o_pc + 1 (combinational)
//   o_ras_empty  RAS holds no entries
//   o_ras_full   RAS holds RAS_DEPTH entries
//   o_ras_ovf    one-cycle pulse after push while full
//   o_ras_unf    one-cycle pulse after pop while empty
module pc_seq
   import pc_pkg::*;
#(
   parameter int ADDR_W    = 7,
   parameter int RESET_VEC = 1,
   parameter int TRAP_VEC  = 0,
   parameter int RAS_DEPTH = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_stall,
   input  logic                i_trap,
   input  logic [PC_SEL_W-1:0] i_pc_sel,
   input  logic [ADDR_W-1:0]   i_br_off,
   input  logic [ADDR_W-1:0]   i_jmp_tgt,
   output logic [ADDR_W-1:0]   o_pc,
   output logic [ADDR_W-1:0]   o_pc_plus1,
   output logic                o_ras_empty,
   output logic                o_ras_full,
   output logic                o_ras_ovf,
   output logic                o_ras_unf
);

   localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_VEC);
   localparam logic [ADDR_W-1:0] PC_TRP = ADDR_W'(TRAP_VEC);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_next;
   logic [ADDR_W-1:0] w_pc_plus1;
   pc_sel_t           w_sel;

   assign w_sel      = pc_sel_t'(i_pc_sel);
   assign w_pc_plus1 = r_pc + PC_ONE;

`ifdef PC_RAS_EN
   logic              w_adv;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_ras_top;
   logic              w_ras_empty;

   // Stack only moves on edges where the PC itself advances.
   assign w_adv  = !i_trap && !i_stall;
   assign w_push = w_adv && (w_sel == PC_CALL);
   assign w_pop  = w_adv && (w_sel == PC_RET);

   pc_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_pc_plus1),
      .o_top   (w_ras_top),
      .o_empty (w_ras_empty),
      .o_full  (o_ras_full),
      .o_ovf   (o_ras_ovf),
      .o_unf   (o_ras_unf)
   );

   assign o_ras_empty = w_ras_empty;
`else
   assign o_ras_empty = 1'b1;
   assign o_ras_full  = 1'b0;
   assign o_ras_ovf   = 1'b0;
   assign o_ras_unf   = 1'b0;
`endif

   always_comb begin
      w_pc_next = w_pc_plus1;
      case (w_sel)
         PC_BR:   w_pc_next = r_pc + i_br_off;
         PC_JMP:  w_pc_next = i_jmp_tgt;
         PC_CALL: w_pc_next = i_jmp_tgt;
`ifdef PC_RAS_EN
         // Empty stack falls back to the jump target.
         PC_RET:  w_pc_next = w_ras_empty ? i_jmp_tgt : w_ras_top;
`else
         PC_RET:  w_pc_next = i_jmp_tgt;
`endif
         default: w_pc_next = w_pc_plus1;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_pc <= PC_RST;
      end else if (i_trap) begin
         r_pc <= PC_TRP;
      end else if (!i_stall) begin
         r_pc <= w_pc_next;
      end
   end

   assign o_pc       = r_pc;
   assign o_pc_plus1 = w_pc_plus1;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: self-checking bench for pc_seq with default parameters.
// Reference model keeps the PC as an integer and the return stack as a queue
// (newest at the back, oldest dropped from the front when over depth).
module tb_pc_seq;
   import pc_pkg::*;

   localparam int AW    = 7;
   localparam int MODN  = 128;
   localparam int RVEC  = 1;
   localparam int TVEC  = 0;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset;
   logic          stall;
   logic          trap;
   logic [2:0]    pc_sel;
   logic [AW-1:0] br_off;
   logic [AW-1:0] jmp_tgt;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_plus1;
   logic          ras_empty;
   logic          ras_full;
   logic          ras_ovf;
   logic          ras_unf;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   int m_pc;
   int m_ras[$];
   int m_ovf;
   int m_unf;

   pc_seq #(
      .ADDR_W    (AW),
      .RESET_VEC (RVEC),
      .TRAP_VEC  (TVEC),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_stall     (stall),
      .i_trap      (trap),
      .i_pc_sel    (pc_sel),
      .i_br_off    (br_off),
      .i_jmp_tgt   (jmp_tgt),
      .o_pc        (pc),
      .o_pc_plus1  (pc_plus1),
      .o_ras_empty (ras_empty),
      .o_ras_full  (ras_full),
      .o_ras_ovf   (ras_ovf),
      .o_ras_unf   (ras_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int m_empty();
`ifdef PC_RAS_EN
      return (m_ras.size() == 0) ? 1 : 0;
`else
      return 1;
`endif
   endfunction

   function automatic int m_full();
`ifdef PC_RAS_EN
      return (m_ras.size() == DEPTH) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_pc = RVEC;
      m_ras.delete();
      m_ovf = 0;
      m_unf = 0;
   endtask

   task automatic model_edge(bit tr, bit st, int sel, int off, int tgt);
      m_ovf = 0;
      m_unf = 0;
      if (tr) begin
         m_pc = TVEC;
      end else if (!st) begin
         case (sel)
            1: m_pc = (m_pc + off) % MODN;
            2: m_pc = tgt;
            3: begin
`ifdef PC_RAS_EN
               m_ras.push_back((m_pc + 1) % MODN);
               if (m_ras.size() > DEPTH) begin
                  void'(m_ras.pop_front());
                  m_ovf = 1;
               end
`endif
               m_pc = tgt;
            end
            4: begin
`ifdef PC_RAS_EN
               if (m_ras.size() == 0) begin
                  m_pc  = tgt;
                  m_unf = 1;
               end else begin
                  m_pc = m_ras.pop_back();
               end
`else
               m_pc = tgt;
`endif
            end
            default: m_pc = (m_pc + 1) % MODN;
         endcase
      end
   endtask

   // Drive inputs, take one rising edge, advance the model, settle.
   task automatic step(bit tr, bit st, int sel, int off, int tgt);
      trap    = tr;
      stall   = st;
      pc_sel  = sel[2:0];
      br_off  = off[AW-1:0];
      jmp_tgt = tgt[AW-1:0];
      @(posedge clk);
      if (!reset) model_reset();
      else        model_edge(tr, st, sel, off, tgt);
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("pc", pc, m_pc);
         check("pc_plus1", pc_plus1, (m_pc + 1) % MODN);
         check("ras_empty", ras_empty, m_empty());
         check("ras_full", ras_full, m_full());
         check("ras_ovf", ras_ovf, m_ovf);
         check("ras_unf", ras_unf, m_unf);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; stall = 1'b0; trap = 1'b0;
      pc_sel = 3'd0; br_off = '0; jmp_tgt = '0;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check("reset_pc", pc, 1);
      check("reset_empty", ras_empty, 1);
      check("reset_full", ras_full, 0);
      chk_en = 1;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("held_reset_pc", pc, 1);
      #3 reset = 1'b1;

      // Release then three increments
      step(0, 0, 0, 0, 0); check("inc1", pc, 2);
      step(0, 0, 0, 0, 0); check("inc2", pc, 3);
      step(0, 0, 0, 0, 0); check("inc3", pc, 4);

      // Asynchronous reset mid-run
      reset = 1'b0;
      model_reset();
      #1 check("async_reset_pc", pc, 1);
      step(0, 0, 0, 0, 0);
      reset = 1'b1;
      step(0, 0, 0, 0, 0); check("after_rst_inc", pc, 2);

      // Wrap and negative branch
      step(0, 0, 2, 0, 127); check("jmp127", pc, 127);
      step(0, 0, 0, 0, 0);   check("wrap", pc, 0);
      step(0, 0, 2, 0, 5);
      step(0, 0, 1, 'h7E, 0); check("br_neg2", pc, 3);

      // Call / inc / return
      step(0, 0, 2, 0, 10);
      step(0, 0, 3, 0, 40); check("call_pc", pc, 40);
`ifdef PC_RAS_EN
      check("call_empty", ras_empty, 0);
`endif
      step(0, 0, 0, 0, 0);  check("call_inc", pc, 41);
      step(0, 0, 4, 0, 77);
`ifdef PC_RAS_EN
      check("ret_pc", pc, 11);
      check("ret_empty", ras_empty, 1);
`else
      check("ret_pc", pc, 77);
`endif

      // Overflow and underflow
      step(0, 0, 2, 0, 0);
      for (int i = 1; i <= 5; i++) begin
         step(0, 0, 3, 0, 10 * i);
`ifdef PC_RAS_EN
         check("ovf_pulse", ras_ovf, (i == 5) ? 1 : 0);
`endif
      end
`ifdef PC_RAS_EN
      for (int i = 4; i >= 1; i--) begin
         step(0, 0, 4, 0, 100);
         check("ret_seq", pc, 10 * i + 1);
      end
      step(0, 0, 4, 0, 9);
      check("unf_pc", pc, 9);
      check("unf_pulse", ras_unf, 1);
      step(0, 0, 0, 0, 0);
      check("unf_clear", ras_unf, 0);
`endif

      // Stall with CALL, then trap over stall
      step(0, 0, 2, 0, 50);
      step(0, 1, 3, 0, 60); check("stall_pc1", pc, 50);
      step(0, 1, 3, 0, 60); check("stall_pc2", pc, 50);
`ifdef PC_RAS_EN
      check("stall_empty", ras_empty, 1);
`endif
      step(1, 1, 3, 0, 60); check("trap_pc", pc, 0);

`ifndef PC_RAS_EN
      step(0, 0, 3, 0, 20); check("noras_call", pc, 20);
      step(0, 0, 4, 0, 30); check("noras_ret", pc, 30);
      check("noras_empty", ras_empty, 1);
      check("noras_full", ras_full, 0);
      check("noras_ovf", ras_ovf, 0);
      check("noras_unf", ras_unf, 0);
`endif

      // Randomized traffic, RET/CALL weighted up to exercise the stack
      for (int n = 0; n < 3000; n++) begin
         int sel;
         sel = (($urandom_range(0, 3) == 0) ? 3 : 0) + int'($urandom_range(0, 7));
         if (sel > 7) sel = 3;
         if ($urandom_range(0, 4) == 0) sel = 4;
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
              sel, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
      end

      @(negedge clk);
      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
